// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame levels, FSM states, parity helper.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // Even-parity bit: the value that makes data plus parity hold an even count of ones.
    // Callers zero-extend narrower data, which does not change the XOR.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, DATA_BITS data (LSB first), even parity, stop.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, waiting for a low level to begin a frame
// S_START  | start bit seen, waiting for mid-bit to confirm it
// S_DATA   | sampling data bits, one every CLKS_PER_BIT cycles
// S_PARITY | sampling the parity bit
// S_STOP   | sampling the stop bit, then publishing byte and flags
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 stop_error,
    output logic                 parity_error,
    output logic                 data_valid
);
    import uart_pkg::*;

    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // The clock counter is a down-counter: a sample is taken when it reaches zero.
    localparam logic [CNT_W-1:0] MID_LOAD = (MID > 0) ? CNT_W'(MID - 1) : '0;
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_t              r_state,     w_state_nx;
    logic [CNT_W-1:0]       r_clk_cnt,   w_clk_cnt_nx;
    logic [BIT_W-1:0]       r_bit_cnt,   w_bit_cnt_nx;
    logic [DATA_BITS-1:0]   r_shift,     w_shift_nx;
    logic                   r_par_bit,   w_par_bit_nx;
    logic [DATA_BITS-1:0]   r_data,      w_data_nx;
    logic                   r_stop_err,  w_stop_err_nx;
    logic                   r_par_err,   w_par_err_nx;
    logic                   r_valid,     w_valid_nx;
    logic                   w_tick;

    assign w_tick = (r_clk_cnt == '0);

    // Register all state; reset aborts any frame in progress without a valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_data     <= '0;
            r_stop_err <= 1'b0;
            r_par_err  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_clk_cnt  <= w_clk_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_par_bit  <= w_par_bit_nx;
            r_data     <= w_data_nx;
            r_stop_err <= w_stop_err_nx;
            r_par_err  <= w_par_err_nx;
            r_valid    <= w_valid_nx;
        end
    end

    // Next-state and datapath decisions; outputs hold unless a stop bit is sampled.
    always_comb begin
        w_state_nx    = r_state;
        w_clk_cnt_nx  = r_clk_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_par_bit_nx  = r_par_bit;
        w_data_nx     = r_data;
        w_stop_err_nx = r_stop_err;
        w_par_err_nx  = r_par_err;
        w_valid_nx    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (serial_in == START_LEVEL) begin
                    w_bit_cnt_nx = '0;
                    // With a zero mid-point the start edge is also its own confirmation.
                    if (MID == 0) begin
                        w_state_nx   = S_DATA;
                        w_clk_cnt_nx = BIT_LOAD;
                    end else begin
                        w_state_nx   = S_START;
                        w_clk_cnt_nx = MID_LOAD;
                    end
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (serial_in == START_LEVEL) begin
                        w_state_nx   = S_DATA;
                        w_clk_cnt_nx = BIT_LOAD;
                        w_bit_cnt_nx = '0;
                    end else begin
                        w_state_nx   = S_IDLE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nx   = {serial_in, r_shift[DATA_BITS-1:1]};
                    w_clk_cnt_nx = BIT_LOAD;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nx = S_PARITY;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_bit_nx = serial_in;
                    w_clk_cnt_nx = BIT_LOAD;
                    w_state_nx   = S_STOP;
                end else begin
                    w_clk_cnt_nx = r_clk_cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_data_nx     = r_shift;
                    w_par_err_nx  = (r_par_bit != even_parity(32'(r_shift)));
                    w_stop_err_nx = (serial_in != STOP_LEVEL);
                    w_valid_nx    = 1'b1;
                    w_clk_cnt_nx  = '0;
                    w_state_nx    = S_IDLE;
                end else begin
                    w_clk_cnt_nx = r_clk_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_clk_cnt_nx = '0;
            end
        endcase
    end

    assign data_out     = r_data;
    assign stop_error   = r_stop_err;
    assign parity_error = r_par_err;
    assign data_valid   = r_valid;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at one and four clocks per bit.
module tb_uart_rx_frame;

    logic       clk;
    logic       rst;
    logic       s1, s2;
    logic [7:0] d1, d2;
    logic       se1, se2, pe1, pe2, dv1, dv2;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int nv1    = 0;
    int nv2    = 0;
    int vlog1[$];

    uart_rx_frame #(.CLKS_PER_BIT(1), .DATA_BITS(8)) u_dut1 (
        .clk(clk), .rst(rst), .serial_in(s1),
        .data_out(d1), .stop_error(se1), .parity_error(pe1), .data_valid(dv1)
    );

    uart_rx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut4 (
        .clk(clk), .rst(rst), .serial_in(s2),
        .data_out(d2), .stop_error(se2), .parity_error(pe2), .data_valid(dv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count and valid-pulse log (reads pre-edge values of the pulses).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dv1) begin
            nv1 <= nv1 + 1;
            vlog1.push_back(cyc);
        end
        if (dv2) nv2 <= nv2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a falling edge; returns on the falling edge after
    // the last stop-bit cycle, with the line still at the stop level.
    task automatic send(input int which, input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        int cpb;
        bits = {stp, par, d, 1'b0};
        cpb  = (which == 1) ? 1 : 4;
        for (int i = 0; i < 11; i++) begin
            if (which == 1) s1 = bits[i]; else s2 = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    int base;
    int base2;
    logic [7:0] frame5;

    initial begin
        rst = 1'b1;
        s1  = 1'b1;
        s2  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data1",  {24'd0, d1}, 32'h0);
        chk("rst_flags1", {29'd0, se1, pe1, dv1}, 32'h0);
        chk("rst_data4",  {24'd0, d2}, 32'h0);
        chk("rst_flags4", {29'd0, se2, pe2, dv2}, 32'h0);
        rst = 1'b0;
        idle(3);

        // 1: clean frame F1, parity 1
        base = nv1;
        send(1, 8'hF1, 1'b1, 1'b1);
        chk("t1_data",  {24'd0, d1}, 32'hF1);
        chk("t1_perr",  {31'd0, pe1}, 32'h0);
        chk("t1_serr",  {31'd0, se1}, 32'h0);
        chk("t1_valid", {31'd0, dv1}, 32'h1);
        idle(2);
        chk("t1_vlow",  {31'd0, dv1}, 32'h0);
        chk("t1_npulse", nv1 - base, 32'd1);

        // 2: same frame, parity bit wrong
        send(1, 8'hF1, 1'b0, 1'b1);
        chk("t2_data", {24'd0, d1}, 32'hF1);
        chk("t2_perr", {31'd0, pe1}, 32'h1);
        chk("t2_serr", {31'd0, se1}, 32'h0);
        idle(2);
        chk("t2_sticky", {31'd0, pe1}, 32'h1);

        // 3: 55 with stop bit low, then clean A5 clears flags
        send(1, 8'h55, 1'b0, 1'b0);
        s1 = 1'b1;
        chk("t3_data", {24'd0, d1}, 32'h55);
        chk("t3_serr", {31'd0, se1}, 32'h1);
        chk("t3_perr", {31'd0, pe1}, 32'h0);
        idle(3);
        send(1, 8'hA5, 1'b0, 1'b1);
        chk("t3b_data", {24'd0, d1}, 32'hA5);
        chk("t3b_flags", {30'd0, se1, pe1}, 32'h0);
        idle(2);

        // 4: back-to-back 01 then FE
        base = nv1;
        vlog1.delete();
        send(1, 8'h01, 1'b1, 1'b1);
        chk("t4_data0", {24'd0, d1}, 32'h01);
        chk("t4_valid0", {31'd0, dv1}, 32'h1);
        send(1, 8'hFE, 1'b1, 1'b1);
        chk("t4_data1", {24'd0, d1}, 32'hFE);
        chk("t4_flags", {30'd0, se1, pe1}, 32'h0);
        idle(2);
        chk("t4_npulse", nv1 - base, 32'd2);
        if (vlog1.size() == 2) chk("t4_gap", vlog1[1] - vlog1[0], 32'd11);
        else chk("t4_logsize", vlog1.size(), 32'd2);

        // 5: reset during data bit 4
        base   = nv1;
        frame5 = 8'hFF;
        s1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s1 = frame5[i];
            @(negedge clk);
        end
        s1  = frame5[4];
        rst = 1'b1;
        #1;
        chk("t5_rst_data", {24'd0, d1}, 32'h0);
        @(negedge clk);
        s1 = 1'b1;
        @(negedge clk);
        chk("t5_rst_flags", {29'd0, se1, pe1, dv1}, 32'h0);
        rst = 1'b0;
        idle(3);
        chk("t5_nopulse", nv1 - base, 32'd0);
        chk("t5_data_held", {24'd0, d1}, 32'h0);
        send(1, 8'h3C, 1'b0, 1'b1);
        s1 = 1'b1;
        chk("t5_data", {24'd0, d1}, 32'h3C);
        chk("t5_flags", {30'd0, se1, pe1}, 32'h0);

        // 6: four clocks per bit; one-cycle glitch then a real frame
        base2 = nv2;
        s2 = 1'b0;
        @(negedge clk);
        s2 = 1'b1;
        idle(12);
        chk("t6_glitch_np", nv2 - base2, 32'd0);
        chk("t6_glitch_d",  {24'd0, d2}, 32'h0);
        send(2, 8'h81, 1'b0, 1'b1);
        idle(2);
        chk("t6_data",   {24'd0, d2}, 32'h81);
        chk("t6_flags",  {30'd0, se2, pe2}, 32'h0);
        chk("t6_npulse", nv2 - base2, 32'd1);
        send(2, 8'h81, 1'b1, 1'b1);
        idle(2);
        chk("t6_perr",   {31'd0, pe2}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
